// File: rtl/timer_rx.sv
// timer_rx -- receive-side framing timer for the serial miner link.
//
// Counts bit strobes into bytes of BITS_PER_BYTE bits, and bytes into packets
// of SHORT_LEN or LONG_LEN bytes. The length is chosen by short_pkt when a
// packet is started. It also flags framing errors: an abort, a restart in the
// middle of a packet, or (optionally) a strobe timeout.
//
// Optional feature: define RX_TIMEOUT_EN to enable a watchdog in RECV. The
// watchdog aborts the packet after TIMEOUT_CYC consecutive cycles with no
// bit strobe.
//
// Ports:
//   clk             in   system clock, rising edge
//   n_rst           in   asynchronous active-low reset
//   start_rx        in   begin a new packet (single-cycle pulse)
//   bit_strobe      in   one serial bit sampled this cycle
//   short_pkt       in   length select, sampled when start_rx is accepted
//   abort           in   terminate the current packet
//   byte_received   out  registered 1-cycle pulse per completed byte
//   packet_received out  registered 1-cycle pulse per completed packet
//   byte_index      out  bytes completed in the current/last packet
//   rx_active       out  high while receiving
//   framing_error   out  sticky error, cleared by the next accepted start_rx
module timer_rx #(
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned SHORT_LEN     = 5,
  parameter int unsigned LONG_LEN      = 34,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_rx,
  input  logic       bit_strobe,
  input  logic       short_pkt,
  input  logic       abort,
  output logic       byte_received,
  output logic       packet_received,
  output logic [5:0] byte_index,
  output logic       rx_active,
  output logic       framing_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_BIT    = 4'(BITS_PER_BYTE - 1);
  localparam logic [5:0] SHORT_LEN_W = 6'(SHORT_LEN);
  localparam logic [5:0] LONG_LEN_W  = 6'(LONG_LEN);

  // Elaboration-time parameter checks; byte_index is 6 bits and never wraps.
  if (LONG_LEN > 63 || LONG_LEN < 1) begin : g_long_len_chk
    $error("timer_rx: LONG_LEN must be in 1..63");
  end
  if (SHORT_LEN > 63 || SHORT_LEN < 1) begin : g_short_len_chk
    $error("timer_rx: SHORT_LEN must be in 1..63");
  end
  if (BITS_PER_BYTE < 2 || BITS_PER_BYTE > 15) begin : g_bpb_chk
    $error("timer_rx: BITS_PER_BYTE must be in 2..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("timer_rx: TIMEOUT_CYC must be at least 1");
  end

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] target_len_q, target_len_d;
  logic [5:0] byte_index_q, byte_index_d;
  logic       byte_received_q, byte_received_d;
  logic       packet_received_q, packet_received_d;
  logic       framing_error_q, framing_error_d;
  logic [5:0] byte_index_inc;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign byte_index_inc = byte_index_q + 6'd1;

  always_comb begin
    state_d           = state_q;
    bit_cnt_d         = bit_cnt_q;
    target_len_d      = target_len_q;
    byte_index_d      = byte_index_q;
    framing_error_d   = framing_error_q;
    byte_received_d   = 1'b0;
    packet_received_d = 1'b0;
`ifdef RX_TIMEOUT_EN
    wd_d              = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_rx) begin
          state_d         = RECV;
          target_len_d    = short_pkt ? SHORT_LEN_W : LONG_LEN_W;
          bit_cnt_d       = '0;
          byte_index_d    = '0;
          framing_error_d = 1'b0;
`ifdef RX_TIMEOUT_EN
          wd_d            = '0;
`endif
        end
      end
      RECV: begin
        if (abort) begin
          state_d         = ERR;
          framing_error_d = 1'b1;
        end else if (start_rx) begin
          // A restart only counts as an error once the packet has begun.
          if (bit_cnt_q != '0 || byte_index_q != '0) framing_error_d = 1'b1;
          target_len_d = short_pkt ? SHORT_LEN_W : LONG_LEN_W;
          bit_cnt_d    = '0;
          byte_index_d = '0;
`ifdef RX_TIMEOUT_EN
          wd_d         = '0;
`endif
        end else if (bit_strobe) begin
`ifdef RX_TIMEOUT_EN
          wd_d = '0;
`endif
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d       = '0;
            byte_index_d    = byte_index_inc;
            byte_received_d = 1'b1;
            if (byte_index_inc == target_len_q) begin
              packet_received_d = 1'b1;
              state_d           = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
`ifdef RX_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d         = ERR;
          framing_error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      DONE: state_d = IDLE;
      ERR: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q           <= IDLE;
      bit_cnt_q         <= '0;
      target_len_q      <= '0;
      byte_index_q      <= '0;
      byte_received_q   <= 1'b0;
      packet_received_q <= 1'b0;
      framing_error_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      wd_q              <= '0;
`endif
    end else begin
      state_q           <= state_d;
      bit_cnt_q         <= bit_cnt_d;
      target_len_q      <= target_len_d;
      byte_index_q      <= byte_index_d;
      byte_received_q   <= byte_received_d;
      packet_received_q <= packet_received_d;
      framing_error_q   <= framing_error_d;
`ifdef RX_TIMEOUT_EN
      wd_q              <= wd_d;
`endif
    end
  end

  assign byte_received   = byte_received_q;
  assign packet_received = packet_received_q;
  assign byte_index      = byte_index_q;
  assign rx_active       = (state_q == RECV);
  assign framing_error   = framing_error_q;

endmodule
